// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, operand-select codes and the pipeline slot record
package cpu_pkg;

  localparam int REG_AW = 3;

  localparam logic [1:0] SEL_REG    = 2'b00;
  localparam logic [1:0] SEL_FWD_B  = 2'b01;
  localparam logic [1:0] SEL_FWD_A  = 2'b10;
  localparam logic [1:0] SEL_FWD_AB = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              is_load;
  } slot_t;

endpackage

// File: rtl/alu_fwd_ctrl_if.sv
// alu_fwd_ctrl_if: decode-side request and EX/WB slot status of the forwarding controller
interface alu_fwd_ctrl_if #(
  parameter int REG_AW = cpu_pkg::REG_AW
) ();

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic              flush;
  logic              ext_stall;
  logic              id_ready;
  logic              ex_valid;
  logic [1:0]        ex_select;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_rd_we;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_rd_we;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
           id_is_load, flush, ext_stall,
    input  id_ready, ex_valid, ex_select, ex_rd, ex_rd_we, wb_valid, wb_rd, wb_rd_we
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
           id_is_load, flush, ext_stall,
    output id_ready, ex_valid, ex_select, ex_rd, ex_rd_we, wb_valid, wb_rd, wb_rd_we
  );

endinterface

// File: rtl/alu_fwd_cmp.sv
// alu_fwd_cmp: does one decode source read the register the EX instruction is producing
module alu_fwd_cmp #(
  parameter int REG_AW   = cpu_pkg::REG_AW,
  parameter int ZERO_REG = 1
) (
  input  logic              ex_valid_i,
  input  logic              ex_rd_we_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              src_used_i,
  input  logic [REG_AW-1:0] src_i,
  output logic              match_o
);

  logic zero_hit;

  // r0 never produces a forwardable value when it is hard-wired
  assign zero_hit = (ZERO_REG != 0) && (ex_rd_i == '0);
  assign match_o  = ex_valid_i & ex_rd_we_i & src_used_i & (src_i == ex_rd_i) & ~zero_hit;

endmodule

// File: rtl/alu_fwd_ctrl.sv
// alu_fwd_ctrl: ID->EX->WB issue/forwarding controller with one-bubble load-use interlock
// Optional ALU_FWD_STATS_EN adds saturating forward and load-use stall counters.
module alu_fwd_ctrl #(
  parameter int REG_AW   = cpu_pkg::REG_AW,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_fwd_ctrl_if.slave bus
`ifdef ALU_FWD_STATS_EN
  ,
  output logic [15:0]  fwd_cnt,
  output logic [15:0]  stall_cnt
`endif
);

  import cpu_pkg::*;

  slot_t             ex_q, ex_d;
  logic [1:0]        sel_q, sel_d;
  logic              wb_valid_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic              wb_rd_we_q;
  logic              match_a, match_b, load_use, issue;

  alu_fwd_cmp #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_cmp_a (
    .ex_valid_i (ex_q.valid),
    .ex_rd_we_i (ex_q.rd_we),
    .ex_rd_i    (ex_q.rd),
    .src_used_i (bus.id_rs1_used),
    .src_i      (bus.id_rs1),
    .match_o    (match_a)
  );

  alu_fwd_cmp #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_cmp_b (
    .ex_valid_i (ex_q.valid),
    .ex_rd_we_i (ex_q.rd_we),
    .ex_rd_i    (ex_q.rd),
    .src_used_i (bus.id_rs2_used),
    .src_i      (bus.id_rs2),
    .match_o    (match_b)
  );

  // a load's result is not on exout yet, so a dependent op waits one slot; flush overrides
  always_comb begin
    load_use = bus.id_valid & ex_q.is_load & (match_a | match_b);
    issue    = bus.id_valid & ~bus.flush & ~load_use;
    ex_d     = issue ? slot_t'{1'b1, bus.id_rd, bus.id_rd_we, bus.id_is_load} : slot_t'('0);
    sel_d    = issue ? {match_a & ~ex_q.is_load, match_b & ~ex_q.is_load} : SEL_REG;
  end

  assign bus.id_ready  = ~bus.ext_stall & (bus.flush | ~load_use);
  assign bus.ex_valid  = ex_q.valid;
  assign bus.ex_select = sel_q;
  assign bus.ex_rd     = ex_q.rd;
  assign bus.ex_rd_we  = ex_q.rd_we;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_rd_we  = wb_rd_we_q;

  // EX/WB slots advance together and freeze as a whole under ext_stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      sel_q      <= SEL_REG;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_rd_we_q <= 1'b0;
    end else if (!bus.ext_stall) begin
      ex_q       <= ex_d;
      sel_q      <= sel_d;
      wb_valid_q <= ex_q.valid;
      wb_rd_q    <= ex_q.rd;
      wb_rd_we_q <= ex_q.rd_we;
    end
  end

`ifdef ALU_FWD_STATS_EN
  logic [15:0] fwd_cnt_q, fwd_cnt_d, stall_cnt_q, stall_cnt_d;

  // counters saturate instead of wrapping so long runs still read as "at least this many"
  always_comb begin
    fwd_cnt_d   = (issue && sel_d != SEL_REG && fwd_cnt_q != 16'hFFFF) ? fwd_cnt_q + 16'd1 : fwd_cnt_q;
    stall_cnt_d = (load_use && !bus.flush && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  // statistics registers hold with the pipe during ext_stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (!bus.ext_stall) begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt   = fwd_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_fwd_ctrl.sv
// tb_alu_fwd_ctrl: directed checks of two controllers (ZERO_REG=1 and ZERO_REG=0) against a pipe model
module tb_alu_fwd_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid = 0, u1 = 0, u2 = 0, we = 0, ld = 0, flush = 0, ext_stall = 0;
  logic [2:0] rs1 = 0, rs2 = 0, rd = 0;

  alu_fwd_ctrl_if #(.REG_AW(3)) bus_a ();
  alu_fwd_ctrl_if #(.REG_AW(3)) bus_b ();

  assign bus_a.id_valid = id_valid;  assign bus_b.id_valid = id_valid;
  assign bus_a.id_rs1 = rs1;         assign bus_b.id_rs1 = rs1;
  assign bus_a.id_rs2 = rs2;         assign bus_b.id_rs2 = rs2;
  assign bus_a.id_rs1_used = u1;     assign bus_b.id_rs1_used = u1;
  assign bus_a.id_rs2_used = u2;     assign bus_b.id_rs2_used = u2;
  assign bus_a.id_rd = rd;           assign bus_b.id_rd = rd;
  assign bus_a.id_rd_we = we;        assign bus_b.id_rd_we = we;
  assign bus_a.id_is_load = ld;      assign bus_b.id_is_load = ld;
  assign bus_a.flush = flush;        assign bus_b.flush = flush;
  assign bus_a.ext_stall = ext_stall; assign bus_b.ext_stall = ext_stall;

`ifdef ALU_FWD_STATS_EN
  logic [15:0] fc_a, sc_a, fc_b, sc_b;
`endif

  alu_fwd_ctrl #(.REG_AW(3), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
`ifdef ALU_FWD_STATS_EN
    , .fwd_cnt(fc_a), .stall_cnt(sc_a)
`endif
  );

  alu_fwd_ctrl #(.REG_AW(3), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
`ifdef ALU_FWD_STATS_EN
    , .fwd_cnt(fc_b), .stall_cnt(sc_b)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: index 0 = ZERO_REG=1 instance, index 1 = ZERO_REG=0 instance.
  // m_* is the instruction sitting in EX, w_* the one in WB.
  bit m_v[2], m_we[2], m_ld[2], w_v[2], w_we[2];
  int m_rd[2], m_sel[2], w_rd[2], m_fc[2], m_sc[2];

  function automatic bit reads_ex(int k, int rs, bit used);
    return m_v[k] && m_we[k] && used && rs == m_rd[k] && !(k == 0 && rs == 0);
  endfunction

  function automatic bit hazard(int k);
    return id_valid && m_ld[k] && (reads_ex(k, rs1, u1) || reads_ex(k, rs2, u2));
  endfunction

  function automatic bit exp_ready(int k);
    return !ext_stall && (flush || !hazard(k));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_v[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_rd[k] = 0; m_sel[k] = 0;
        w_v[k] = 0; w_we[k] = 0; w_rd[k] = 0; m_fc[k] = 0; m_sc[k] = 0;
      end else if (!ext_stall) begin
        bit hz, a, b, go;
        int sel;
        hz = hazard(k);
        a = reads_ex(k, rs1, u1);
        b = reads_ex(k, rs2, u2);
        go = id_valid && !flush && !hz;
        sel = go ? (a ? 2 : 0) + (b ? 1 : 0) : 0;
        if (go && sel != 0 && m_fc[k] < 65535) m_fc[k]++;
        if (hz && !flush && m_sc[k] < 65535) m_sc[k]++;
        w_v[k] = m_v[k]; w_we[k] = m_we[k]; w_rd[k] = m_rd[k];
        m_v[k] = go; m_we[k] = go && we; m_ld[k] = go && ld; m_rd[k] = go ? int'(rd) : 0; m_sel[k] = sel;
      end
    end
  end

  task automatic chk(int k, logic rdy, logic v, logic [1:0] s, logic [2:0] r, logic w,
                     logic wv, logic [2:0] wr, logic ww);
    cmp($sformatf("id_ready[%0d]", k), rdy, exp_ready(k));
    cmp($sformatf("ex_valid[%0d]", k), v, m_v[k]);
    cmp($sformatf("ex_select[%0d]", k), s, m_sel[k]);
    cmp($sformatf("ex_rd_we[%0d]", k), w, m_we[k]);
    if (m_v[k]) cmp($sformatf("ex_rd[%0d]", k), r, m_rd[k]);
    cmp($sformatf("wb_valid[%0d]", k), wv, w_v[k]);
    cmp($sformatf("wb_rd_we[%0d]", k), ww, w_we[k]);
    if (w_v[k]) cmp($sformatf("wb_rd[%0d]", k), wr, w_rd[k]);
  endtask

  always @(negedge clk) begin
    chk(0, bus_a.id_ready, bus_a.ex_valid, bus_a.ex_select, bus_a.ex_rd, bus_a.ex_rd_we,
        bus_a.wb_valid, bus_a.wb_rd, bus_a.wb_rd_we);
    chk(1, bus_b.id_ready, bus_b.ex_valid, bus_b.ex_select, bus_b.ex_rd, bus_b.ex_rd_we,
        bus_b.wb_valid, bus_b.wb_rd, bus_b.wb_rd_we);
`ifdef ALU_FWD_STATS_EN
    cmp("fwd_cnt[0]", fc_a, m_fc[0]);
    cmp("fwd_cnt[1]", fc_b, m_fc[1]);
    cmp("stall_cnt[0]", sc_a, m_sc[0]);
    cmp("stall_cnt[1]", sc_b, m_sc[1]);
`endif
  end

  task automatic set(bit v, int a, int b, bit ua, bit ub, int d, bit dw, bit dl,
                     bit fl = 0, bit st = 0);
    id_valid = v; rs1 = 3'(a); rs2 = 3'(b); u1 = ua; u2 = ub;
    rd = 3'(d); we = dw; ld = dl; flush = fl; ext_stall = st;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pin_sel(string nm, int ea, int eb);
    cmp({nm, " model sel0"}, m_sel[0], ea);
    cmp({nm, " model sel1"}, m_sel[1], eb);
    cmp({nm, " sel0"}, bus_a.ex_select, ea);
    cmp({nm, " sel1"}, bus_b.ex_select, eb);
  endtask

  task automatic pin_zero(string nm);
    cmp({nm, " ex_valid"}, bus_a.ex_valid | bus_b.ex_valid, 0);
    cmp({nm, " ex_select"}, bus_a.ex_select | bus_b.ex_select, 0);
    cmp({nm, " ex_rd"}, bus_a.ex_rd | bus_b.ex_rd, 0);
    cmp({nm, " ex_rd_we"}, bus_a.ex_rd_we | bus_b.ex_rd_we, 0);
    cmp({nm, " wb_valid"}, bus_a.wb_valid | bus_b.wb_valid, 0);
    cmp({nm, " wb_rd"}, bus_a.wb_rd | bus_b.wb_rd, 0);
    cmp({nm, " wb_rd_we"}, bus_a.wb_rd_we | bus_b.wb_rd_we, 0);
`ifdef ALU_FWD_STATS_EN
    cmp({nm, " counters"}, fc_a | sc_a | fc_b | sc_b, 0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    pin_zero("reset");
    rst_n = 1'b1;

    set(1, 2, 3, 1, 1, 1, 1, 0); cmp("add r1 ready", bus_a.id_ready, 1); tick();
    pin_sel("add r1", 0, 0); cmp("add r1 ex_rd", bus_a.ex_rd, 1);
    set(1, 1, 3, 1, 1, 2, 1, 0); tick(); pin_sel("fwd a", 2, 2);
    set(1, 4, 2, 1, 1, 3, 1, 0); tick(); pin_sel("fwd b", 1, 1);
    set(1, 3, 3, 1, 1, 4, 1, 0); tick(); pin_sel("fwd ab", 3, 3);

    set(1, 5, 6, 1, 1, 4, 1, 1); tick(); pin_sel("load r4", 0, 0);
    set(1, 4, 6, 1, 1, 5, 1, 0);
    cmp("lu ready", bus_a.id_ready, 0); cmp("lu model ready", exp_ready(0), 0);
    tick();
    cmp("lu bubble valid", bus_a.ex_valid, 0); pin_sel("lu bubble", 0, 0);
    cmp("lu wb_rd", bus_a.wb_rd, 4);
    cmp("lu retry ready", bus_a.id_ready, 1);
    tick();
    pin_sel("lu issue", 0, 0); cmp("lu issue valid", bus_a.ex_valid, 1); cmp("lu issue rd", bus_a.ex_rd, 5);

    set(1, 7, 7, 1, 1, 0, 1, 0); tick(); pin_sel("add r0", 0, 0);
    set(1, 0, 0, 1, 1, 1, 1, 0); tick(); pin_sel("zero reg", 0, 3);

    set(1, 3, 3, 1, 1, 2, 1, 1); tick(); pin_sel("load r2", 0, 0);
    set(1, 2, 4, 1, 1, 6, 1, 0, 1); cmp("flush ready", bus_a.id_ready, 1); tick();
    cmp("flush bubble", bus_a.ex_valid, 0); pin_sel("flush bubble", 0, 0);
    set(1, 2, 4, 1, 1, 5, 1, 0); cmp("post flush ready", bus_a.id_ready, 1); tick();
    cmp("post flush valid", bus_a.ex_valid, 1); pin_sel("post flush", 0, 0);

    set(1, 4, 4, 1, 1, 3, 1, 0); tick(); pin_sel("add r3", 0, 0);
    set(1, 3, 0, 1, 0, 6, 1, 0, 0, 1); cmp("stall ready", bus_a.id_ready, 0);
    repeat (3) begin
      tick();
      cmp("stall ex_rd", bus_a.ex_rd, 3); cmp("stall wb_rd", bus_a.wb_rd, 5);
      pin_sel("stall hold", 0, 0);
    end
    set(1, 3, 0, 1, 0, 6, 1, 0); tick();
    pin_sel("stall release", 2, 2); cmp("release wb_rd", bus_a.wb_rd, 3);

`ifdef ALU_FWD_STATS_EN
    cmp("fwd_cnt A", fc_a, 4); cmp("fwd_cnt B", fc_b, 5);
    cmp("stall_cnt A", sc_a, 1); cmp("stall_cnt B", sc_b, 1);
    set(1, 1, 1, 1, 1, 1, 1, 0);
    repeat (70000) tick();
    cmp("fwd_cnt sat", fc_a, 16'hFFFF); cmp("model fwd sat", m_fc[0], 65535);
`endif

    set(1, 6, 0, 1, 0, 1, 1, 0); tick();
    set(1, 1, 0, 1, 0, 2, 1, 0); tick(); pin_sel("pre reset", 2, 2);
    #2 rst_n = 1'b0;
    #1 pin_zero("async reset");
    tick();
    rst_n = 1'b1;
    set(1, 2, 0, 1, 0, 3, 1, 0); tick();
    pin_sel("after reset", 0, 0); cmp("after reset valid", bus_a.ex_valid, 1);
    set(1, 3, 0, 1, 0, 4, 1, 0); tick(); pin_sel("after reset fwd", 2, 2);
    set(1, 4, 4, 0, 0, 5, 1, 0); tick(); pin_sel("unused srcs", 0, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0); tick(); cmp("idle bubble", bus_a.ex_valid, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
